// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- multiplexed 4-digit display scanner with a shadow/active
// digit register pair.
//
// Each digit slot is BLANK dark cycles (anti-ghosting) followed by
// DIV-BLANK lit cycles. A frame covers digits 0..3, which is 4*DIV cycles.
// Digit values are written into a shadow register. A commit copies shadow
// into the active register at a frame boundary, so a frame never shows a
// mix of old and new digits. While the scanner is idle, a commit copies
// immediately.
//
// Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  synchronous active-high reset
//   run     in  1  1 = scan digits, 0 = dark and idle
//   wr      in  1  shadow write strobe
//   waddr   in  2  shadow digit index
//   wdata   in  2  shadow digit value
//   commit  in  1  request shadow -> active copy
//   an      out 4  digit anodes, active-low
//   A       out 2  encoder data (active digit value while lit)
//   EN      out 1  encoder enable, active-low
//   frame   out 1  one-cycle pulse after the digit 3 -> 0 wrap
//   pending out 1  commit accepted, waiting for the wrap
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       wr,
  input  logic [1:0] waddr,
  input  logic [1:0] wdata,
  input  logic       commit,
  output logic [3:0] an,
  output logic [1:0] A,
  output logic       EN,
  output logic       frame,
  output logic       pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [1:0]      idx_r, idx_s;
  logic [3:0][1:0] shadow_r, shadow_s;
  logic [3:0][1:0] active_r, active_s;
  logic            pending_s;
  logic            frame_s;
  logic [3:0]      an_s;
  logic [1:0]      a_s;
  logic            en_s;

  // Next-state, register-file and next-output computation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shadow_s  = shadow_r;
    active_s  = active_r;
    pending_s = pending;
    frame_s   = 1'b0;

    // The shadow update is folded in first so any copy made at this
    // edge sees the concurrent write.
    if (wr) begin
      shadow_s[waddr] = wdata;
    end else begin
      shadow_s = shadow_r;
    end

    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        idx_s = 2'd0;
        if (commit) begin
          active_s  = shadow_s;
          pending_s = 1'b0;
        end else begin
          active_s = active_r;
        end
        if (run) begin
          state_s = ST_BLANK;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BLANK: begin
        pending_s = pending | commit;
        if (!run) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          idx_s   = 2'd0;
        end else if (cnt_r == CW'(BLANK - 1)) begin
          state_s = ST_SHOW;
          cnt_s   = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end

      ST_SHOW: begin
        if (!run) begin
          state_s   = ST_IDLE;
          cnt_s     = '0;
          idx_s     = 2'd0;
          pending_s = pending | commit;
        end else if (cnt_r == CW'(DIV - 1)) begin
          state_s = ST_BLANK;
          cnt_s   = '0;
          idx_s   = idx_r + 2'd1;
          // Frame boundary: the only point where a deferred commit lands.
          if (idx_r == 2'd3) begin
            frame_s = 1'b1;
            if (pending || commit) begin
              active_s  = shadow_s;
              pending_s = 1'b0;
            end else begin
              pending_s = pending;
            end
          end else begin
            pending_s = pending | commit;
          end
        end else begin
          cnt_s     = cnt_r + CW'(1);
          pending_s = pending | commit;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        idx_s   = 2'd0;
      end
    endcase

    // Outputs are derived from the post-edge state so the registered
    // outputs line up with the state they describe.
    if (state_s == ST_SHOW) begin
      an_s = ~(4'b0001 << idx_s);
      a_s  = active_s[idx_s];
      en_s = 1'b0;
    end else begin
      an_s = 4'b1111;
      a_s  = 2'd0;
      en_s = 1'b1;
    end
  end

  // State, digit registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      idx_r    <= 2'd0;
      shadow_r <= '0;
      active_r <= '0;
      pending  <= 1'b0;
      frame    <= 1'b0;
      an       <= 4'b1111;
      A        <= 2'd0;
      EN       <= 1'b1;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shadow_r <= shadow_s;
      active_r <= active_s;
      pending  <= pending_s;
      frame    <= frame_s;
      an       <= an_s;
      A        <= a_s;
      EN       <= en_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIV=8, BLANK=2). A frame-time model tracks the
// position t inside a 4*DIV frame; digit = t/DIV, lit when t%DIV >= BLANK.
// Outputs are compared against it every cycle, and directed literal checks
// pin the model to hand-computed values.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRM   = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst, run, wr, commit;
  logic [1:0] waddr, wdata;
  logic [3:0] an;
  logic [1:0] A;
  logic       EN, frame, pending;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .run(run), .wr(wr), .waddr(waddr), .wdata(wdata),
    .commit(commit), .an(an), .A(A), .EN(EN), .frame(frame), .pending(pending)
  );

  always #5 clk = ~clk;

  // Model state
  bit model_ok = 1'b0;
  bit m_run, m_pend, m_frame;
  int m_t;
  int m_sh[4];
  int m_act[4];
  int nsh[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model update on each edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    nsh = m_sh;
    if (wr) nsh[waddr] = int'(wdata);
    if (rst) begin
      m_run = 0; m_pend = 0; m_frame = 0; m_t = 0;
      foreach (m_sh[i]) begin m_sh[i] = 0; m_act[i] = 0; end
    end else if (!m_run) begin
      if (commit) begin m_act = nsh; m_pend = 0; end
      m_run = run; m_t = 0; m_frame = 0; m_sh = nsh;
    end else if (!run) begin
      m_run = 0; m_t = 0; m_frame = 0;
      if (commit) m_pend = 1;
      m_sh = nsh;
    end else begin
      if (m_t == FRM - 1) begin
        m_t = 0; m_frame = 1;
        if (m_pend || commit) begin m_act = nsh; m_pend = 0; end
      end else begin
        m_t++; m_frame = 0;
        if (commit) m_pend = 1;
      end
      m_sh = nsh;
    end
    model_ok = 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int dig, ph, e_an, e_a, e_en;
    if (model_ok) begin
      dig = m_t / DIV;
      ph  = m_t % DIV;
      if (m_run && ph >= BLANK) begin
        e_an = 15 & ~(1 << dig);
        e_a  = m_act[dig];
        e_en = 0;
      end else begin
        e_an = 15; e_a = 0; e_en = 1;
      end
      chk("model_an", int'(an), e_an);
      chk("model_A", int'(A), e_a);
      chk("model_EN", int'(EN), e_en);
      chk("model_frame", int'(frame), int'(m_frame));
      chk("model_pending", int'(pending), int'(m_pend));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run = 1'b0; wr = 1'b0; commit = 1'b0; waddr = 2'd0; wdata = 2'd0;
    step(2);
    rst = 1'b0;
    chk("rst_an", int'(an), 15);
    chk("rst_EN", int'(EN), 1);
    chk("rst_A", int'(A), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_pending", int'(pending), 0);

    // Load active = {0,1,2,3} from idle, commit with the last write.
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; waddr = 2'(i); wdata = 2'(i); commit = (i == 3);
      step(1);
    end
    wr = 1'b0; commit = 1'b0;
    chk("idle_commit_pending", int'(pending), 0);

    // Basic scan timing.
    run = 1'b1;
    step(1);  chk("slot0_blank_an", int'(an), 15); chk("slot0_blank_EN", int'(EN), 1);
    step(2);  chk("slot0_lit_an", int'(an), 4'b1110); chk("slot0_lit_A", int'(A), 0);
              chk("slot0_lit_EN", int'(EN), 0);
    step(8);  chk("slot1_lit_an", int'(an), 4'b1101); chk("slot1_lit_A", int'(A), 1);
    step(22); chk("wrap_frame", int'(frame), 1);
    step(1);  chk("after_wrap_frame", int'(frame), 0);

    // Deferred commit during digit 1 (t is 1 here).
    step(8);
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; waddr = 2'(i); wdata = 2'(3 - i); commit = (i == 3);
      step(1);
    end
    wr = 1'b0; commit = 1'b0;
    chk("deferred_pending", int'(pending), 1);
    step(13); chk("old_digit3_A", int'(A), 3); chk("old_digit3_an", int'(an), 4'b0111);
              chk("still_pending", int'(pending), 1);
    step(6);  chk("applied_pending", int'(pending), 0); chk("applied_frame", int'(frame), 1);
    step(2);  chk("new_digit0_A", int'(A), 3); chk("new_digit0_an", int'(an), 4'b1110);

    // run=0 during digit 2, then restart from digit 0.
    step(18);
    run = 1'b0;
    step(1);  chk("stop_an", int'(an), 15); chk("stop_EN", int'(EN), 1);
    run = 1'b1;
    step(1);  chk("restart_blank_an", int'(an), 15);
    step(2);  chk("restart_digit0_an", int'(an), 4'b1110); chk("restart_digit0_A", int'(A), 3);

    // Commit + write on the exact wrap edge.
    step(29);
    commit = 1'b1; wr = 1'b1; waddr = 2'd0; wdata = 2'd2;
    step(1);
    commit = 1'b0; wr = 1'b0;
    chk("wrapcommit_pending", int'(pending), 0); chk("wrapcommit_frame", int'(frame), 1);
    step(2);  chk("wrapcommit_A", int'(A), 2);

    // Reset mid-SHOW with a pending commit.
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    chk("pre_rst_pending", int'(pending), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_an", int'(an), 15); chk("midrst_EN", int'(EN), 1);
    chk("midrst_A", int'(A), 0); chk("midrst_pending", int'(pending), 0);
    step(3);  chk("postrst_digit0_an", int'(an), 4'b1110); chk("postrst_digit0_A", int'(A), 0);
    step(8);  chk("postrst_digit1_an", int'(an), 4'b1101); chk("postrst_digit1_A", int'(A), 0);

    // Idle write + commit in the same cycle.
    run = 1'b0;
    step(1);
    wr = 1'b1; waddr = 2'd2; wdata = 2'd3; commit = 1'b1;
    step(1);
    wr = 1'b0; commit = 1'b0;
    chk("idle_wc_pending", int'(pending), 0);
    run = 1'b1;
    step(19); chk("idle_wc_digit2_an", int'(an), 4'b1011); chk("idle_wc_digit2_A", int'(A), 3);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
